// File: rtl/stepper_pkg.sv
`default_nettype none
// ============================================================================
// stepper_pkg : phase codes, FSM states and decode helpers for the decoder
// Revision    : 1.0
// ============================================================================
package stepper_pkg;

    localparam logic [3:0] PH0    = 4'b0001;
    localparam logic [3:0] PH1    = 4'b0010;
    localparam logic [3:0] PH2    = 4'b0100;
    localparam logic [3:0] PH3    = 4'b1000;
    localparam logic [3:0] PH_OFF = 4'b0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } phase_dec_t;

    function automatic phase_dec_t decode_phase(input logic [3:0] code);
        phase_dec_t d;
        d.valid = 1'b1;
        d.idx   = 2'd0;
        case (code)
            PH0:     d.idx = 2'd0;
            PH1:     d.idx = 2'd1;
            PH2:     d.idx = 2'd2;
            PH3:     d.idx = 2'd3;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    // 2-bit subtraction gives the forward distance modulo 4
    function automatic logic [1:0] phase_delta(input logic [1:0] new_idx,
                                               input logic [1:0] old_idx);
        return new_idx - old_idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_filter.sv
`default_nettype none
// ============================================================================
// phase_filter : coil-pattern synchronizer plus N-sample stability filter
// Revision     : 1.0
// ============================================================================
module phase_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] pin_async,
    output logic [3:0] code,
    output logic       accept
);

    localparam int                CNT_W   = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0][3:0] r_sync;
    logic [3:0]                  w_sync_out;
    logic [3:0]                  r_cand;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin_async};
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // accept is registered on the cycle the count first reaches its limit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cand   <= '0;
            r_cnt    <= '0;
            r_accept <= 1'b0;
        end else if (w_sync_out != r_cand) begin
            r_cand   <= w_sync_out;
            r_cnt    <= CNT_W'(1);
            r_accept <= (FILTER_CYCLES == 1);
        end else if (r_cnt != CNT_MAX) begin
            r_cnt    <= r_cnt + 1'b1;
            r_accept <= ((r_cnt + 1'b1) == CNT_MAX);
        end else begin
            r_accept <= 1'b0;
        end
    end

    assign code   = r_cand;
    assign accept = r_accept;

endmodule
`default_nettype wire

// File: rtl/stepper_phase_decoder.sv
`default_nettype none
// ============================================================================
// stepper_phase_decoder : wave-drive coil monitor tracking position, direction
//                         and illegal/skip/stall conditions
// Revision              : 1.0
// ============================================================================
module stepper_phase_decoder
    import stepper_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int POS_W         = 16,
    parameter int STALL_CYCLES  = 1000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       motorpin,
    input  logic             pos_clr,
    input  logic             err_clr,
    output logic             step_pulse,
    output logic             dir,
    output logic [POS_W-1:0] position,
    output logic [1:0]       phase_idx,
    output logic             locked,
    output logic             stalled,
    output logic             err_illegal,
    output logic             err_skip
);

    localparam int                STALL_W   = $clog2(STALL_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);

    logic [3:0]         w_code;
    logic               w_accept;
    phase_dec_t         w_dec;
    logic [1:0]         w_delta;

    state_t             r_state,    w_state_nxt;
    logic [1:0]         r_phase,    w_phase_nxt;
    logic [POS_W-1:0]   r_pos,      w_pos_nxt;
    logic               r_dir,      w_dir_nxt;
    logic               r_step,     w_step_nxt;
    logic               r_err_ill,  w_err_ill_nxt;
    logic               r_err_skip, w_err_skip_nxt;
    logic [STALL_W-1:0] r_stall,    w_stall_nxt;
    logic               w_set_ill;
    logic               w_set_skip;

    phase_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .clk       (clk),
        .reset_n   (reset_n),
        .pin_async (motorpin),
        .code      (w_code),
        .accept    (w_accept)
    );

    always_comb begin
        w_dec       = decode_phase(w_code);
        w_delta     = phase_delta(w_dec.idx, r_phase);
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_dir_nxt   = r_dir;
        w_step_nxt  = 1'b0;
        w_set_ill   = 1'b0;
        w_set_skip  = 1'b0;

        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (w_dec.valid) begin
                        w_state_nxt = TRACK;
                        w_phase_nxt = w_dec.idx;
                    end else if (w_code != PH_OFF) begin
                        w_state_nxt = FAULT;
                        w_set_ill   = 1'b1;
                    end
                end
                TRACK: begin
                    if (w_dec.valid) begin
                        case (w_delta)
                            2'd1: begin
                                w_step_nxt  = 1'b1;
                                w_dir_nxt   = 1'b1;
                                w_phase_nxt = w_dec.idx;
                            end
                            2'd3: begin
                                w_step_nxt  = 1'b1;
                                w_dir_nxt   = 1'b0;
                                w_phase_nxt = w_dec.idx;
                            end
                            2'd2: begin
                                w_set_skip  = 1'b1;
                                w_phase_nxt = w_dec.idx;
                            end
                            default: ;
                        endcase
                    end else if (w_code == PH_OFF) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = FAULT;
                        w_set_ill   = 1'b1;
                    end
                end
                FAULT: begin
                    if (w_dec.valid) begin
                        w_state_nxt = TRACK;
                        w_phase_nxt = w_dec.idx;
                    end else if (w_code == PH_OFF) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        // pos_clr overrides any concurrent step
        if (pos_clr) begin
            w_pos_nxt = '0;
        end else if (w_step_nxt) begin
            w_pos_nxt = w_dir_nxt ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
        end else begin
            w_pos_nxt = r_pos;
        end

        w_err_ill_nxt  = w_set_ill  | (r_err_ill  & ~err_clr);
        w_err_skip_nxt = w_set_skip | (r_err_skip & ~err_clr);

        if ((r_state != TRACK) || (w_state_nxt != TRACK) || w_step_nxt || w_set_skip) begin
            w_stall_nxt = '0;
        end else if (r_stall != STALL_MAX) begin
            w_stall_nxt = r_stall + 1'b1;
        end else begin
            w_stall_nxt = r_stall;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            r_pos      <= '0;
            r_dir      <= 1'b0;
            r_step     <= 1'b0;
            r_err_ill  <= 1'b0;
            r_err_skip <= 1'b0;
            r_stall    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_pos      <= w_pos_nxt;
            r_dir      <= w_dir_nxt;
            r_step     <= w_step_nxt;
            r_err_ill  <= w_err_ill_nxt;
            r_err_skip <= w_err_skip_nxt;
            r_stall    <= w_stall_nxt;
        end
    end

    assign step_pulse  = r_step;
    assign dir         = r_dir;
    assign position    = r_pos;
    assign phase_idx   = r_phase;
    assign locked      = (r_state == TRACK);
    assign stalled     = (r_stall == STALL_MAX);
    assign err_illegal = r_err_ill;
    assign err_skip    = r_err_skip;

endmodule
`default_nettype wire

// File: tb/tb_stepper_phase_decoder.sv
`default_nettype none
// ============================================================================
// tb_stepper_phase_decoder : directed vector bench for stepper_phase_decoder
// Revision                 : 1.0
// ============================================================================
module tb_stepper_phase_decoder;

    localparam int SYNC_STAGES   = 2;
    localparam int FILTER_CYCLES = 4;
    localparam int POS_W         = 4;
    localparam int STALL_CYCLES  = 20;
    localparam int HOLD          = 10;
    localparam int NV            = 29;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [3:0]       motorpin;
    logic             pos_clr;
    logic             err_clr;
    logic             step_pulse;
    logic             dir;
    logic [POS_W-1:0] position;
    logic [1:0]       phase_idx;
    logic             locked;
    logic             stalled;
    logic             err_illegal;
    logic             err_skip;

    int checks = 0;
    int errors = 0;
    int step_total = 0;

    typedef struct {
        logic [3:0]       mp;
        logic             pclr;
        logic             eclr;
        int               steps;
        logic             dir;
        logic [POS_W-1:0] pos;
        logic [1:0]       idx;
        logic             locked;
        logic             eill;
        logic             eskip;
    } vec_t;

    vec_t tbl [NV];

    stepper_phase_decoder #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES),
        .POS_W         (POS_W),
        .STALL_CYCLES  (STALL_CYCLES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .motorpin    (motorpin),
        .pos_clr     (pos_clr),
        .err_clr     (err_clr),
        .step_pulse  (step_pulse),
        .dir         (dir),
        .position    (position),
        .phase_idx   (phase_idx),
        .locked      (locked),
        .stalled     (stalled),
        .err_illegal (err_illegal),
        .err_skip    (err_skip)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step_pulse === 1'b1) step_total++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] mp, input logic pclr, input logic eclr,
                                input int steps, input logic d, input logic [POS_W-1:0] pos,
                                input logic [1:0] idx, input logic lk, input logic eill,
                                input logic eskip);
        vec_t v;
        v.mp = mp; v.pclr = pclr; v.eclr = eclr; v.steps = steps; v.dir = d;
        v.pos = pos; v.idx = idx; v.locked = lk; v.eill = eill; v.eskip = eskip;
        return v;
    endfunction

    initial begin
        int s0;
        int n;
        int lat;
        logic [POS_W-1:0] pos_save;

        //               mp       pc eclr st dir pos   idx lk ill skip
        tbl[0]  = mk(4'b0001, 0, 0, 0, 0, 4'd0,  0, 1, 0, 0);
        tbl[1]  = mk(4'b0010, 0, 0, 1, 1, 4'd1,  1, 1, 0, 0);
        tbl[2]  = mk(4'b0100, 0, 0, 1, 1, 4'd2,  2, 1, 0, 0);
        tbl[3]  = mk(4'b1000, 0, 0, 1, 1, 4'd3,  3, 1, 0, 0);
        tbl[4]  = mk(4'b0001, 0, 0, 1, 1, 4'd4,  0, 1, 0, 0);
        tbl[5]  = mk(4'b1000, 0, 0, 1, 0, 4'd3,  3, 1, 0, 0);
        tbl[6]  = mk(4'b0100, 0, 0, 1, 0, 4'd2,  2, 1, 0, 0);
        tbl[7]  = mk(4'b0010, 0, 0, 1, 0, 4'd1,  1, 1, 0, 0);
        tbl[8]  = mk(4'b0001, 0, 0, 1, 0, 4'd0,  0, 1, 0, 0);
        tbl[9]  = mk(4'b1000, 0, 0, 1, 0, 4'd15, 3, 1, 0, 0);
        tbl[10] = mk(4'b0100, 0, 0, 1, 0, 4'd14, 2, 1, 0, 0);
        tbl[11] = mk(4'b0010, 0, 0, 1, 0, 4'd13, 1, 1, 0, 0);
        tbl[12] = mk(4'b0001, 0, 0, 1, 0, 4'd12, 0, 1, 0, 0);
        tbl[13] = mk(4'b1000, 0, 0, 1, 0, 4'd11, 3, 1, 0, 0);
        tbl[14] = mk(4'b0100, 0, 0, 1, 0, 4'd10, 2, 1, 0, 0);
        tbl[15] = mk(4'b0010, 0, 0, 1, 0, 4'd9,  1, 1, 0, 0);
        tbl[16] = mk(4'b0001, 0, 0, 1, 0, 4'd8,  0, 1, 0, 0);  // -8
        tbl[17] = mk(4'b1000, 0, 0, 1, 0, 4'd7,  3, 1, 0, 0);  // wraps to +7
        tbl[18] = mk(4'b0001, 0, 0, 1, 1, 4'd8,  0, 1, 0, 0);
        tbl[19] = mk(4'b0100, 0, 0, 0, 1, 4'd8,  2, 1, 0, 1);
        tbl[20] = mk(4'b0011, 0, 0, 0, 1, 4'd8,  2, 0, 1, 1);
        tbl[21] = mk(4'b1000, 0, 0, 0, 1, 4'd8,  3, 1, 1, 1);
        tbl[22] = mk(4'b1000, 0, 1, 0, 1, 4'd8,  3, 1, 0, 0);
        tbl[23] = mk(4'b0001, 1, 0, 1, 1, 4'd0,  0, 1, 0, 0);
        tbl[24] = mk(4'b0000, 0, 0, 0, 1, 4'd0,  0, 0, 0, 0);
        tbl[25] = mk(4'b0011, 0, 0, 0, 1, 4'd0,  0, 0, 1, 0);
        tbl[26] = mk(4'b0000, 0, 0, 0, 1, 4'd0,  0, 0, 1, 0);
        tbl[27] = mk(4'b0010, 0, 0, 0, 1, 4'd0,  1, 1, 1, 0);
        tbl[28] = mk(4'b0010, 0, 1, 0, 1, 4'd0,  1, 1, 0, 0);

        reset_n  = 1'b0;
        motorpin = 4'b0000;
        pos_clr  = 1'b0;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_outputs", {step_pulse, dir, position, phase_idx, locked, stalled,
                                err_illegal, err_skip}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            motorpin = tbl[i].mp;
            pos_clr  = tbl[i].pclr;
            err_clr  = tbl[i].eclr;
            s0       = step_total;
            repeat (HOLD) @(negedge clk);
            check($sformatf("v%0d_steps", i), step_total - s0, tbl[i].steps);
            check($sformatf("v%0d_dir", i), dir, tbl[i].dir);
            check($sformatf("v%0d_pos", i), position, tbl[i].pos);
            check($sformatf("v%0d_idx", i), phase_idx, tbl[i].idx);
            check($sformatf("v%0d_locked", i), locked, tbl[i].locked);
            check($sformatf("v%0d_err_ill", i), err_illegal, tbl[i].eill);
            check($sformatf("v%0d_err_skip", i), err_skip, tbl[i].eskip);
            pos_clr = 1'b0;
            err_clr = 1'b0;
        end

        // Glitch shorter than the filter window must not produce a step
        @(negedge clk);
        motorpin = 4'b0001;
        repeat (HOLD) @(negedge clk);
        pos_save = position;
        s0       = step_total;
        motorpin = 4'b0010;
        repeat (FILTER_CYCLES - 1) @(negedge clk);
        motorpin = 4'b0001;
        repeat (15) @(negedge clk);
        check("glitch_steps", step_total - s0, 0);
        check("glitch_pos", position, pos_save);
        check("glitch_idx", phase_idx, 2'd0);

        // Latency from the sampling edge to the step pulse
        motorpin = 4'b0010;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (step_pulse === 1'b1) begin
                lat = i - 1;
                break;
            end
        end
        check("latency", lat, SYNC_STAGES + FILTER_CYCLES);
        repeat (5) @(negedge clk);

        // pos_clr coinciding with a forward step
        motorpin = 4'b0100;
        repeat (SYNC_STAGES + FILTER_CYCLES) @(negedge clk);
        pos_clr = 1'b1;
        @(negedge clk);
        check("clr_step_pulse", step_pulse, 1'b1);
        check("clr_step_pos", position, 4'd0);
        check("clr_step_dir", dir, 1'b1);
        pos_clr = 1'b0;
        repeat (3) @(negedge clk);

        // Stall detection
        motorpin = 4'b0000;
        repeat (HOLD) @(negedge clk);
        check("idle_stalled", stalled, 1'b0);
        check("idle_locked", locked, 1'b0);
        motorpin = 4'b0010;
        n = 0;
        while (locked !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_lock", locked, 1'b1);
        n = 0;
        while (stalled !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("stall_cycles", n, STALL_CYCLES);
        motorpin = 4'b0100;
        n = 0;
        while (step_pulse !== 1'b1 && n < 15) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("stall_clr_by_step", stalled, 1'b0);
        check("stall_step_pos", position, 4'd1);
        repeat (25) @(negedge clk);
        check("stall_again", stalled, 1'b1);
        motorpin = 4'b0000;
        repeat (HOLD) @(negedge clk);
        check("stall_leave", stalled, 1'b0);
        check("stall_leave_locked", locked, 1'b0);

        // Asynchronous reset between clock edges
        motorpin = 4'b0001;
        repeat (HOLD) @(negedge clk);
        check("pre_reset_locked", locked, 1'b1);
        check("pre_reset_dir", dir, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {step_pulse, dir, position, phase_idx, locked, stalled,
                              err_illegal, err_skip}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stepper_phase_decoder.md
Name: stepper_phase_decoder

Overview:
- Receive-side monitor for the 4-wire wave-drive stepper interface: samples the coil pattern on `motorpin`, which may be asynchronous to `clk`.
- Filters glitches, decodes each stable pattern to a phase index and tracks signed position and direction.
- Flags illegal patterns, skipped phases and stalls.
- Sits beside the motor driver for closed-loop checking, or on a second board watching the coil lines.

Parameters:
- SYNC_STAGES, 2, flops in the input synchronizer chain (min 2).
- FILTER_CYCLES, 4, consecutive identical synchronized samples required before a pattern is accepted (min 1).
- POS_W, 16, width of the signed position counter.
- STALL_CYCLES, 1000000, cycles without a step in TRACK before `stalled` asserts.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- motorpin, input, 4, coil pattern; asynchronous to clk.
- pos_clr, input, 1, synchronous clear of position to 0.
- err_clr, input, 1, synchronous clear of sticky error flags.
- step_pulse, output, 1, one-cycle pulse per decoded step.
- dir, output, 1, direction of last step: 1 = forward, 0 = reverse.
- position, output, POS_W, signed step count (two's complement).
- phase_idx, output, 2, current accepted phase index.
- locked, output, 1, high in TRACK.
- stalled, output, 1, no step for STALL_CYCLES while in TRACK.
- err_illegal, output, 1, sticky: an illegal pattern was accepted.
- err_skip, output, 1, sticky: a phase jump of 2 was accepted.

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; filter counter, stall counter and synchronizer flops cleared.
- Codes:
  - Legal: 4'b0001 = idx 0, 4'b0010 = idx 1, 4'b0100 = idx 2, 4'b1000 = idx 3.
  - Off: 4'b0000.
  - Illegal: everything else.
- Filter:
  - The synchronized value is compared each cycle with a candidate register.
  - Differ: the candidate is loaded and the count is reset to 1.
  - Equal: the count increments, saturating at FILTER_CYCLES.
  - Accept: an "accept" event fires exactly once, on the cycle the count reaches FILTER_CYCLES.
  - A pattern shorter than FILTER_CYCLES samples is never accepted.
- Latency: a clean `motorpin` change sampled at edge N is accepted at edge N+SYNC_STAGES+FILTER_CYCLES-1. Outputs update on the following edge.
- FSM states and transitions, applied on accept:
  - IDLE:
    - legal → TRACK; load phase_idx; no step.
    - off → stay.
    - illegal → FAULT; set err_illegal.
  - TRACK:
    - Δ = (new - phase_idx) mod 4.
    - Δ = 1: step_pulse, dir = 1, position + 1.
    - Δ = 3: step_pulse, dir = 0, position - 1.
    - Δ = 2: set err_skip; load phase_idx; no step; position unchanged.
    - off → IDLE.
    - illegal → FAULT; set err_illegal.
  - FAULT:
    - legal → TRACK; reacquire phase_idx; no step.
    - off → IDLE.
    - illegal → stay.
- `locked` = (state == TRACK).
- phase_idx holds its last value in IDLE and FAULT.
- Position wraps modulo 2^POS_W; there is no saturation.
- Stall counter:
  - Runs only in TRACK; cleared on each step, on Δ = 2 and on leaving TRACK.
  - Saturates at STALL_CYCLES.
  - `stalled` = counter == STALL_CYCLES; it drops on the cycle after the next step or on leaving TRACK.
- Simultaneous events:
  - pos_clr and a step in the same cycle: position = 0; step_pulse and dir still update.
  - err_clr and a new error in the same cycle: the flag is set (set wins).
- A single step_pulse and position change occur per accept, never more.
- Reset asserted mid-operation: everything returns to reset state immediately, independent of clk.

Decomposition:
- Package stepper_pkg:
  - Phase code constants PH0..PH3 and PH_OFF.
  - State enum {IDLE, TRACK, FAULT}.
  - Function that maps a code to {valid, idx}.
  - Function for modular delta.
- Sub-module phase_filter: synchronizer chain plus stability filter. It outputs the accepted code and a one-cycle accept strobe.
- The top level holds the FSM, position, stall counter and flags.

Test Plan:
- Forward: reset, then drive 0001, 0010, 0100, 1000, 0001, each held 10 cycles → 4 step_pulses, dir = 1, position = 4, phase_idx = 0, locked = 1.
- Reverse from position 4: drive 1000, 0100 → position = 2, dir = 0. Set POS_W = 4, start at -8 and step reverse once → position = 7 (wrap).
- Glitch: from 0001, pulse 0010 for 3 cycles (FILTER_CYCLES = 4), then return to 0001 → no step_pulse, position unchanged. Measure latency from a clean change to step_pulse = SYNC_STAGES + FILTER_CYCLES cycles.
- Faults:
  - From 0001 drive 0100 → err_skip = 1, no step, phase_idx = 2.
  - Then drive 0011 → err_illegal = 1, locked = 0.
  - Then drive 1000 → locked = 1, no step.
  - err_clr → both flags 0.
- Stall with STALL_CYCLES = 20: hold 0010 in TRACK → stalled = 1 after 20 cycles; the next step clears it. Drive 0000 → IDLE, stalled = 0.
- Simultaneous and async reset:
  - pos_clr on the same cycle as a forward step → position = 0, step_pulse = 1.
  - Assert reset_n low mid-sequence between clock edges → all outputs 0 immediately.
